frame_bit_writer: RTL and testbench

FRAME_BIT_WRITER -- requirements
Module: frame_bit_writer

---
 rtl/frame_bit_writer_pkg.sv | 16 +
 rtl/frame_bit_writer_if.sv | 30 +++
 rtl/frame_bit_writer_row_packer.sv | 38 +++
 rtl/frame_bit_writer.sv | 112 +++++++++++
 tb/tb_frame_bit_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_bit_writer_pkg.sv
// Shared constants and FSM encoding for the frame capture path and the correlator.
package frame_bit_writer_pkg;

  localparam int PIX_W  = 8;
  localparam int COLS   = 128;
  localparam int ROWS   = 256;
  localparam int ADDR_W = 9;
  localparam int ROW_W  = ADDR_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FILL  = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/frame_bit_writer_if.sv
// Pixel stream, control and BRAM write port of the frame bit writer.
interface frame_bit_writer_if #(
  parameter int PIX_W = frame_bit_writer_pkg::PIX_W,
  parameter int COLS  = frame_bit_writer_pkg::COLS
);
  import frame_bit_writer_pkg::*;

  logic             go;
  logic [PIX_W-1:0] threshold;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_sof;
  logic [ADDR_W-1:0] bram_addr;
  logic [COLS-1:0]  bram_din;
  logic             bram_we;
  logic             busy;
  logic             frame_done;
  logic             curr_frame_bram_offset_sel;

  modport master (
    output go, threshold, pix_data, pix_valid, pix_sof,
    input  bram_addr, bram_din, bram_we, busy, frame_done, curr_frame_bram_offset_sel
  );

  modport slave (
    input  go, threshold, pix_data, pix_valid, pix_sof,
    output bram_addr, bram_din, bram_we, busy, frame_done, curr_frame_bram_offset_sel
  );

endinterface

// File: rtl/frame_bit_writer_row_packer.sv
// Binarizes accepted pixels and packs them MSB-first into a row word; flags the last column.
module row_packer #(
  parameter int PIX_W = frame_bit_writer_pkg::PIX_W,
  parameter int COLS  = frame_bit_writer_pkg::COLS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             accept,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [PIX_W-1:0] threshold,
  output logic             row_done,
  output logic [COLS-1:0]  row_word
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [CW-1:0]   col_q;
  logic [CW-1:0]   col_eff;
  logic [COLS-1:0] shreg_q;
  logic            pix_bit;

  assign pix_bit  = (pix_data >= threshold);
  // A start pixel is column 0 regardless of where the previous row stopped.
  assign col_eff  = start ? '0 : col_q;
  assign row_done = accept && (col_eff == CW'(COLS - 1));
  assign row_word = {shreg_q[COLS-2:0], pix_bit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q   <= '0;
      shreg_q <= '0;
    end else if (accept) begin
      shreg_q <= row_word;
      col_q   <= row_done ? '0 : col_eff + 1'b1;
    end
  end

endmodule

// File: rtl/frame_bit_writer.sv
// Captures one binarized frame into the idle BRAM bank, one row word per write.
//   state    | meaning
//   ST_IDLE  | waiting for go
//   ST_ARMED | waiting for the start-of-frame pixel
//   ST_FILL  | packing rows; last_q marks the final write cycle
module frame_bit_writer #(
  parameter int PIX_W = frame_bit_writer_pkg::PIX_W,
  parameter int COLS  = frame_bit_writer_pkg::COLS,
  parameter int ROWS  = frame_bit_writer_pkg::ROWS
) (
  input  logic                clk,
  input  logic                resetn,
  frame_bit_writer_if.slave   bus
);
  import frame_bit_writer_pkg::*;

  fbw_state_t        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, row_eff;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   din_q, din_d;
  logic              sof_pix, accept, start, row_done;
  logic [COLS-1:0]   row_word;

  assign sof_pix = bus.pix_valid & bus.pix_sof;
  assign accept  = ((state_q == ST_ARMED) && sof_pix) ||
                   ((state_q == ST_FILL) && !last_q && bus.pix_valid);
  assign start   = bus.pix_sof;
  assign row_eff = start ? '0 : row_q;

  row_packer #(.PIX_W(PIX_W), .COLS(COLS)) u_packer (
    .clk       (clk),
    .resetn    (resetn),
    .accept    (accept),
    .start     (start),
    .pix_data  (bus.pix_data),
    .threshold (bus.threshold),
    .row_done  (row_done),
    .row_word  (row_word)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    last_d  = last_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE:  if (bus.go) state_d = ST_ARMED;
      ST_ARMED: if (sof_pix) begin
        state_d = ST_FILL;
        row_d   = '0;
      end
      ST_FILL: begin
        if (last_q) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
          done_d  = 1'b1;
          sel_d   = ~sel_q;
          row_d   = '0;
        end else if (sof_pix) begin
          row_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The bank stays fixed for the whole frame; the last row ends it without wrapping.
    if (row_done) begin
      we_d   = 1'b1;
      addr_d = {~sel_q, row_eff};
      din_d  = row_word;
      if (row_eff == ROW_W'(ROWS - 1)) last_d = 1'b1;
      else                             row_d  = row_eff + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus.bram_we                    = we_q;
  assign bus.bram_addr                  = addr_q;
  assign bus.bram_din                   = din_q;
  assign bus.frame_done                 = done_q;
  assign bus.busy                       = (state_q != ST_IDLE);
  assign bus.curr_frame_bram_offset_sel = sel_q;

endmodule

// File: tb/tb_frame_bit_writer.sv
// Directed bench: full-size instance for whole frames, small instance for corner cases.
module tb_frame_bit_writer;
  import frame_bit_writer_pkg::*;

  localparam int BC = 8;
  localparam int BR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a, rstn_b;
  int   total = 0;
  int   bad   = 0;

  frame_bit_writer_if #(.PIX_W(8), .COLS(COLS)) ifa ();
  frame_bit_writer_if #(.PIX_W(8), .COLS(BC))   ifb ();

  frame_bit_writer dut_a (.clk(clk), .resetn(rstn_a), .bus(ifa));
  frame_bit_writer #(.PIX_W(8), .COLS(BC), .ROWS(BR)) dut_b (.clk(clk), .resetn(rstn_b), .bus(ifb));

  logic [8:0]      a_addr[$];
  logic [COLS-1:0] a_din[$];
  logic [8:0]      b_addr[$];
  logic [BC-1:0]   b_din[$];
  int   cyc = 0;
  int   a_fd = 0, a_fd_cyc = 0, a_we_cyc = 0, a_wide = 0;
  int   b_fd = 0, b_fd_cyc = 0, b_we_cyc = 0, b_wide = 0;
  logic a_prev_we = 1'b0, b_prev_we = 1'b0;
  logic a_fd_sel = 1'b0, a_fd_busy = 1'b0, b_fd_sel = 1'b0, b_fd_busy = 1'b0;
  logic [BC-1:0] tab [4] = '{8'h3F, 8'h0F, 8'h03, 8'h00};

  always @(negedge clk) begin
    if (ifa.bram_we) begin a_addr.push_back(ifa.bram_addr); a_din.push_back(ifa.bram_din); a_we_cyc = cyc; end
    if (ifa.bram_we && a_prev_we) a_wide++;
    a_prev_we = ifa.bram_we;
    if (ifa.frame_done) begin a_fd++; a_fd_cyc = cyc; a_fd_sel = ifa.curr_frame_bram_offset_sel; a_fd_busy = ifa.busy; end
    if (ifb.bram_we) begin b_addr.push_back(ifb.bram_addr); b_din.push_back(ifb.bram_din); b_we_cyc = cyc; end
    if (ifb.bram_we && b_prev_we) b_wide++;
    b_prev_we = ifb.bram_we;
    if (ifb.frame_done) begin b_fd++; b_fd_cyc = cyc; b_fd_sel = ifb.curr_frame_bram_offset_sel; b_fd_busy = ifb.busy; end
    cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_pix(input logic v, input logic s, input logic [7:0] d);
    ifa.pix_valid = v; ifa.pix_sof = s; ifa.pix_data = d;
    tick();
  endtask

  task automatic a_go();
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
  endtask

  task automatic b_go();
    ifb.go = 1'b1; tick(); ifb.go = 1'b0;
  endtask

  // Row r uses data c*16 against threshold 32*(r+1): rows pack to 3F, 0F, 03, 00.
  task automatic b_frame(input bit gap, input bit go_mid);
    for (int r = 0; r < BR; r++) begin
      for (int c = 0; c < BC; c++) begin
        ifb.go        = go_mid && (r == 2) && (c == 0);
        ifb.pix_valid = 1'b1;
        ifb.pix_sof   = (r == 0) && (c == 0);
        ifb.pix_data  = 8'(c * 16);
        ifb.threshold = 8'(32 * r + 32);
        tick();
        ifb.go = 1'b0;
        if (gap) repeat (2) begin
          ifb.pix_valid = 1'b0; ifb.pix_sof = 1'b1; ifb.pix_data = 8'hFF; ifb.threshold = 8'h00;
          tick();
        end
      end
    end
    ifb.pix_valid = 1'b0; ifb.pix_sof = 1'b0;
    repeat (5) tick();
  endtask

  task automatic b_ones(input int n);
    for (int i = 0; i < n; i++) begin
      ifb.pix_valid = 1'b1; ifb.pix_sof = (i == 0); ifb.pix_data = 8'hFF; ifb.threshold = 8'h00;
      tick();
    end
  endtask

  task automatic chk_b(input string tag, input int off, input logic [8:0] base);
    for (int r = 0; r < BR; r++) begin
      if (off + r < b_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, r), 128'(b_addr[off+r]), 128'(base + 9'(r)));
        chk($sformatf("%s_din%0d", tag, r), 128'(b_din[off+r]), 128'(tab[r]));
      end
    end
  endtask

  task automatic b_clear();
    b_addr.delete(); b_din.delete(); b_fd = 0; b_wide = 0;
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    ifa.go = 0; ifa.threshold = 0; ifa.pix_data = 0; ifa.pix_valid = 0; ifa.pix_sof = 0;
    ifb.go = 0; ifb.threshold = 0; ifb.pix_data = 0; ifb.pix_valid = 0; ifb.pix_sof = 0;
    repeat (3) tick();
    chk("rst_busy", 128'(ifa.busy), 0);
    chk("rst_done", 128'(ifa.frame_done), 0);
    chk("rst_we",   128'(ifa.bram_we), 0);
    chk("rst_sel",  128'(ifa.curr_frame_bram_offset_sel), 0);
    chk("rst_addr", 128'(ifa.bram_addr), 0);
    chk("rst_din",  128'(ifa.bram_din), 0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick();

    // full-size frame 1: all pixels above threshold
    ifa.threshold = 8'd100;
    a_go();
    chk("a_busy_armed", 128'(ifa.busy), 1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        a_pix(1'b1, (r == 0) && (c == 0), 8'd200);
    repeat (5) a_pix(1'b0, 1'b0, 8'd0);
    chk("a1_count", 128'(a_addr.size()), 256);
    for (int i = 0; i < a_addr.size(); i++) begin
      chk($sformatf("a1_addr%0d", i), 128'(a_addr[i]), 128'(256 + i));
      chk($sformatf("a1_din%0d", i), 128'(a_din[i]), {128{1'b1}});
    end
    chk("a1_fd_count", 128'(a_fd), 1);
    chk("a1_fd_delay", 128'(a_fd_cyc - a_we_cyc), 1);
    chk("a1_fd_sel",   128'(a_fd_sel), 1);
    chk("a1_fd_busy",  128'(a_fd_busy), 0);
    chk("a1_sel",      128'(ifa.curr_frame_bram_offset_sel), 1);
    chk("a1_wide",     128'(a_wide), 0);

    // full-size frame 2: alternating 0/255, threshold 128
    a_addr.delete(); a_din.delete(); a_fd = 0;
    ifa.threshold = 8'd128;
    a_go();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        a_pix(1'b1, (r == 0) && (c == 0), (c % 2 == 1) ? 8'd255 : 8'd0);
    repeat (5) a_pix(1'b0, 1'b0, 8'd0);
    chk("a2_count", 128'(a_addr.size()), 256);
    for (int i = 0; i < a_addr.size(); i++) begin
      chk($sformatf("a2_addr%0d", i), 128'(a_addr[i]), 128'(i));
      chk($sformatf("a2_din%0d", i), 128'(a_din[i]), {16{8'h55}});
    end
    chk("a2_fd_count", 128'(a_fd), 1);
    chk("a2_sel",      128'(ifa.curr_frame_bram_offset_sel), 0);

    // small instance: sof alongside go is ignored, then pixels without sof in ARMED
    ifb.go = 1'b1; ifb.pix_valid = 1'b1; ifb.pix_sof = 1'b1; ifb.pix_data = 8'hFF; ifb.threshold = 8'h00;
    tick();
    ifb.go = 1'b0; ifb.pix_sof = 1'b0;
    repeat (10) tick();
    ifb.pix_valid = 1'b0;
    repeat (3) tick();
    chk("b_armed_nowrite", 128'(b_addr.size()), 0);
    chk("b_armed_busy",    128'(ifb.busy), 1);

    // gapped frame with go pulsed mid-frame
    b_frame(1'b1, 1'b1);
    chk("bg_count", 128'(b_addr.size()), 4);
    chk_b("bg", 0, 9'd256);
    chk("bg_wide",     128'(b_wide), 0);
    chk("bg_fd_count", 128'(b_fd), 1);
    chk("bg_fd_delay", 128'(b_fd_cyc - b_we_cyc), 1);
    chk("bg_fd_busy",  128'(b_fd_busy), 0);
    chk("bg_sel",      128'(ifb.curr_frame_bram_offset_sel), 1);

    // same frame, continuous
    b_clear();
    b_go();
    b_frame(1'b0, 1'b0);
    chk("bc_count", 128'(b_addr.size()), 4);
    chk_b("bc", 0, 9'd0);
    chk("bc_fd_sel", 128'(b_fd_sel), 0);
    chk("bc_sel",    128'(ifb.curr_frame_bram_offset_sel), 0);

    // restart at row 2 col 5
    b_clear();
    b_go();
    b_ones(2 * BC + 5);
    b_frame(1'b0, 1'b0);
    chk("br_count", 128'(b_addr.size()), 6);
    if (b_addr.size() >= 2) begin
      chk("br_pre_addr0", 128'(b_addr[0]), 256);
      chk("br_pre_din0",  128'(b_din[0]), 8'hFF);
      chk("br_pre_addr1", 128'(b_addr[1]), 257);
    end
    chk_b("br", 2, 9'd256);
    chk("br_fd_count", 128'(b_fd), 1);
    chk("br_sel",      128'(ifb.curr_frame_bram_offset_sel), 1);

    // reset during row 2
    b_clear();
    b_go();
    b_ones(2 * BC + 3);
    chk("bx_pre_count", 128'(b_addr.size()), 2);
    rstn_b = 1'b0;
    ifb.pix_sof = 1'b0;
    repeat (6) tick();
    chk("bx_rst_count", 128'(b_addr.size()), 2);
    chk("bx_rst_sel",   128'(ifb.curr_frame_bram_offset_sel), 0);
    chk("bx_rst_busy",  128'(ifb.busy), 0);
    rstn_b = 1'b1;
    repeat (4) tick();
    chk("bx_post_count", 128'(b_addr.size()), 2);
    chk("bx_fd_count",   128'(b_fd), 0);
    ifb.pix_valid = 1'b0;
    tick();
    b_go();
    b_frame(1'b0, 1'b0);
    chk("bx_count", 128'(b_addr.size()), 6);
    chk_b("bx", 2, 9'd256);
    chk("bx_sel", 128'(ifb.curr_frame_bram_offset_sel), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
